// File: rtl/detector_impacto_pkg.sv
// Shared game definitions: FSM encodings, screen limits and clock frequency
// used by the hit detector, projectile and shooter blocks.
package detector_impacto_pkg;

  localparam logic [1:0] VIVO         = 2'd0;
  localparam logic [1:0] INVULNERAVEL = 2'd1;
  localparam logic [1:0] MORTO        = 2'd2;

  localparam int unsigned LARGURA_TELA = 640;
  localparam int unsigned ALTURA_TELA  = 480;
  localparam int unsigned FREQ_CLOCK   = 50_000_000;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned VIDAS_W = 3;

endpackage

// File: rtl/detector_impacto_sobreposicao.sv
// Registered circle-vs-rectangle overlap test (bounding-box style, edge contact
// counts). Reusable for any rectangular hitbox.
module comparador_sobreposicao
  import detector_impacto_pkg::*;
#(
  parameter int unsigned LARGURA_ALVO = 40,
  parameter int unsigned ALTURA_ALVO  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x_alvo,
  input  logic [COORD_W-1:0] y_alvo,
  input  logic [COORD_W-1:0] x_bola,
  input  logic [COORD_W-1:0] y_bola,
  input  logic [COORD_W-1:0] raio,
  output logic               ov_q
);

  localparam int unsigned AW = COORD_W + 1;

  logic [AW-1:0] xa, ya, xb, yb, r;
  logic          sobrepoe_c;

  // One extra bit keeps sums near the right/bottom screen edge from wrapping
  assign xa = AW'(x_alvo);
  assign ya = AW'(y_alvo);
  assign xb = AW'(x_bola);
  assign yb = AW'(y_bola);
  assign r  = AW'(raio);

  assign sobrepoe_c = (xb + r >= xa) && (xb <= xa + AW'(LARGURA_ALVO - 1) + r) &&
                      (yb + r >= ya) && (yb <= ya + AW'(ALTURA_ALVO - 1) + r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ov_q <= 1'b0;
    else     ov_q <= sobrepoe_c;
  end

endmodule

// File: rtl/detector_impacto.sv
// Player hit receiver: registers projectile hits, tracks lives, runs the
// invulnerability window (with sprite blink) and flags game over.
module detector_impacto
  import detector_impacto_pkg::*;
#(
  parameter int unsigned LARGURA_ALVO   = 40,
  parameter int unsigned ALTURA_ALVO    = 16,
  parameter int unsigned VIDAS_INICIAIS = 3,
  parameter int unsigned INVULN_CICLOS  = 25_000_000,
  parameter int unsigned BIT_PISCA      = 22
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               pausa,
  input  logic               reiniciarJogo,
  input  logic [COORD_W-1:0] xAlvo,
  input  logic [COORD_W-1:0] yAlvo,
  input  logic [COORD_W-1:0] xBola,
  input  logic [COORD_W-1:0] yBola,
  input  logic [COORD_W-1:0] raioBola,
  input  logic               bolaAtiva,
  input  logic               ehAliada,
  output logic               acerto,
  output logic               consumirBola,
  output logic [VIDAS_W-1:0] vidas,
  output logic               piscar,
  output logic               fimDeJogo
);

  localparam int unsigned TW_BASE = (INVULN_CICLOS > 1) ? $clog2(INVULN_CICLOS) : 1;
  localparam int unsigned TIMER_W = (TW_BASE > BIT_PISCA) ? TW_BASE : BIT_PISCA + 1;

  logic [1:0]         estado, estado_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [VIDAS_W-1:0] vidas_n;
  logic               acerto_n, piscar_n, fim_n;
  logic               ov_q;
  logic               golpe_c;

  comparador_sobreposicao #(
    .LARGURA_ALVO (LARGURA_ALVO),
    .ALTURA_ALVO  (ALTURA_ALVO)
  ) u_comparador (
    .clk    (CLOCK_50),
    .rst    (reset),
    .x_alvo (xAlvo),
    .y_alvo (yAlvo),
    .x_bola (xBola),
    .y_bola (yBola),
    .raio   (raioBola),
    .ov_q   (ov_q)
  );

  assign golpe_c = ov_q & bolaAtiva & ~ehAliada & ~pausa;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      estado       <= VIVO;
      vidas        <= VIDAS_W'(VIDAS_INICIAIS);
      timer        <= '0;
      acerto       <= 1'b0;
      consumirBola <= 1'b0;
      piscar       <= 1'b0;
      fimDeJogo    <= 1'b0;
    end else begin
      estado       <= estado_n;
      vidas        <= vidas_n;
      timer        <= timer_n;
      acerto       <= acerto_n;
      consumirBola <= acerto_n;
      piscar       <= piscar_n;
      fimDeJogo    <= fim_n;
    end
  end

  // Restart outranks any hit landing in the same cycle
  always_comb begin
    estado_n = estado;
    vidas_n  = vidas;
    timer_n  = timer;
    acerto_n = 1'b0;
    if (reiniciarJogo) begin
      estado_n = VIVO;
      vidas_n  = VIDAS_W'(VIDAS_INICIAIS);
      timer_n  = '0;
    end else begin
      case (estado)
        VIVO: begin
          if (golpe_c) begin
            acerto_n = 1'b1;
            vidas_n  = (vidas != '0) ? vidas - VIDAS_W'(1) : '0;
            if (vidas <= VIDAS_W'(1)) begin
              estado_n = MORTO;
            end else begin
              estado_n = INVULNERAVEL;
              timer_n  = TIMER_W'(INVULN_CICLOS - 1);
            end
          end
        end
        INVULNERAVEL: begin
          if (!pausa) begin
            if (timer == '0) estado_n = VIVO;
            else             timer_n  = timer - TIMER_W'(1);
          end
        end
        MORTO:   vidas_n  = '0;
        default: estado_n = VIVO;
      endcase
    end
    piscar_n = (estado_n == INVULNERAVEL) ? timer_n[BIT_PISCA] : 1'b0;
    fim_n    = (estado_n == MORTO);
  end

endmodule

// File: tb/tb_detector_impacto.sv
// Scenario bench for detector_impacto: expected output snapshots are queued
// when stimulus is applied and compared when the DUT should produce them.
module tb_detector_impacto;

  logic       CLOCK_50;
  logic       reset, pausa, reiniciarJogo, bolaAtiva, ehAliada;
  logic [9:0] xAlvo, yAlvo, xBola, yBola, raioBola;
  logic       acerto, consumirBola, piscar, fimDeJogo;
  logic [2:0] vidas;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic       acerto;
    logic       consumir;
    logic [2:0] vidas;
    logic       piscar;
    logic       fim;
  } obs_t;

  obs_t sb[$];

  detector_impacto #(
    .LARGURA_ALVO   (40),
    .ALTURA_ALVO    (16),
    .VIDAS_INICIAIS (3),
    .INVULN_CICLOS  (16),
    .BIT_PISCA      (2)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .pausa         (pausa),
    .reiniciarJogo (reiniciarJogo),
    .xAlvo         (xAlvo),
    .yAlvo         (yAlvo),
    .xBola         (xBola),
    .yBola         (yBola),
    .raioBola      (raioBola),
    .bolaAtiva     (bolaAtiva),
    .ehAliada      (ehAliada),
    .acerto        (acerto),
    .consumirBola  (consumirBola),
    .vidas         (vidas),
    .piscar        (piscar),
    .fimDeJogo     (fimDeJogo)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic obs_t mk(input logic a, input logic c, input logic [2:0] v,
                              input logic p, input logic f);
    mk = {a, c, v, p, f};
  endfunction

  function automatic obs_t dut_obs();
    dut_obs = {acerto, consumirBola, vidas, piscar, fimDeJogo};
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic ball(input int x, input int y, input int r);
    xBola     = 10'(x);
    yBola     = 10'(y);
    raioBola  = 10'(r);
    bolaAtiva = 1'b1;
  endtask

  task automatic ball_away();
    ball(500, 50, 5);
  endtask

  task automatic apply_reset();
    pausa = 1'b0; reiniciarJogo = 1'b0; ehAliada = 1'b0;
    xAlvo = 10'd100; yAlvo = 10'd400;
    ball_away();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    obs_t e, o;
    apply_reset();
    sb.push_back(mk(1'b0, 1'b0, 3'd3, 1'b0, 1'b0));
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL reset_state: got %b expected %b", o, e); else passed++;
  endtask

  task automatic test_hit_latency();
    obs_t e, o;
    apply_reset();
    ball(120, 395, 5);
    sb.push_back(mk(1'b0, 1'b0, 3'd3, 1'b0, 1'b0));
    sb.push_back(mk(1'b1, 1'b1, 3'd2, 1'b1, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 3'd2, 1'b1, 1'b0));
    tick();
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL hit_cycle1: got %b expected %b", o, e); else passed++;
    tick();
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL hit_cycle2: got %b expected %b", o, e); else passed++;
    ball_away();
    tick();
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL hit_pulse_end: got %b expected %b", o, e); else passed++;
  endtask

  // Leftmost contact is centre 95 (95+5 reaches column 100); rightmost is 144
  task automatic test_edges();
    int   xs[6] = '{95, 94, 144, 145, 120, 120};
    int   ys[6] = '{405, 405, 405, 405, 420, 421};
    logic hs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    obs_t e, o;
    for (int i = 0; i < 6; i++) begin
      apply_reset();
      ball(xs[i], ys[i], 5);
      sb.push_back(mk(hs[i], hs[i], hs[i] ? 3'd2 : 3'd3, hs[i], 1'b0));
      tick(); tick();
      e = sb.pop_front(); o = dut_obs(); total++;
      if (o !== e)
        $display("FAIL edge_%0d_%0d: got %b expected %b", xs[i], ys[i], o, e);
      else passed++;
    end
  endtask

  task automatic test_persistent();
    obs_t e, o;
    apply_reset();
    ball(120, 405, 5);
    tick();
    sb.push_back(mk(1'b1, 1'b1, 3'd2, 1'b1, 1'b0));
    for (int i = 1; i < 16; i++)
      sb.push_back(mk(1'b0, 1'b0, 3'd2, 1'((15 - i) >> 2), 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 3'd2, 1'b0, 1'b0));
    sb.push_back(mk(1'b1, 1'b1, 3'd1, 1'b1, 1'b0));
    for (int i = 0; i < 18; i++) begin
      tick();
      e = sb.pop_front(); o = dut_obs(); total++;
      if (o !== e) $display("FAIL persistent_cycle_%0d: got %b expected %b", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_game_over();
    obs_t e, o;
    int   n;
    apply_reset();
    for (int h = 1; h <= 3; h++) begin
      ball(120, 405, 5);
      sb.push_back(mk(1'b1, 1'b1, 3'(3 - h), h < 3, h == 3));
      tick(); tick();
      e = sb.pop_front(); o = dut_obs(); total++;
      if (o !== e) $display("FAIL game_over_hit%0d: got %b expected %b", h, o, e);
      else passed++;
      ball_away();
      repeat (20) tick();
    end
    ball(120, 405, 5);
    n = 0;
    repeat (10) begin
      tick();
      if (acerto !== 1'b0 || consumirBola !== 1'b0) n++;
    end
    total++;
    if (n !== 0) $display("FAIL morto_no_hit: pulses %0d expected 0", n); else passed++;
    sb.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b1));
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL morto_hold: got %b expected %b", o, e); else passed++;
    ball_away();
    reiniciarJogo = 1'b1;
    tick();
    reiniciarJogo = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 3'd3, 1'b0, 1'b0));
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL restart_from_morto: got %b expected %b", o, e); else passed++;
  endtask

  task automatic test_pause();
    obs_t e, o;
    int   n;
    apply_reset();
    pausa = 1'b1;
    ball(120, 405, 5);
    n = 0;
    repeat (8) begin
      tick();
      if (acerto !== 1'b0) n++;
    end
    total++;
    if (n !== 0) $display("FAIL pause_no_hit: pulses %0d expected 0", n); else passed++;
    pausa = 1'b0;
    sb.push_back(mk(1'b1, 1'b1, 3'd2, 1'b1, 1'b0));
    tick();
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL pause_release_hit: got %b expected %b", o, e); else passed++;
    repeat (3) tick();
    pausa = 1'b1;
    n = 0;
    repeat (10) begin
      tick();
      if (piscar !== 1'b1 || acerto !== 1'b0) n++;
    end
    total++;
    if (n !== 0) $display("FAIL pause_freeze: bad cycles %0d expected 0", n); else passed++;
    pausa = 1'b0;
    n = 0;
    repeat (13) begin
      tick();
      if (acerto !== 1'b0) n++;
    end
    total++;
    if (n !== 0) $display("FAIL pause_window_early_hit: pulses %0d expected 0", n); else passed++;
    sb.push_back(mk(1'b1, 1'b1, 3'd1, 1'b1, 1'b0));
    tick();
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL pause_window_extended: got %b expected %b", o, e); else passed++;
  endtask

  task automatic test_ally();
    obs_t e, o;
    int   n;
    apply_reset();
    ehAliada = 1'b1;
    ball(120, 405, 5);
    n = 0;
    repeat (10) begin
      tick();
      if (acerto !== 1'b0 || consumirBola !== 1'b0) n++;
    end
    total++;
    if (n !== 0) $display("FAIL ally_no_hit: pulses %0d expected 0", n); else passed++;
    sb.push_back(mk(1'b0, 1'b0, 3'd3, 1'b0, 1'b0));
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL ally_state: got %b expected %b", o, e); else passed++;
    ehAliada = 1'b0;
    sb.push_back(mk(1'b1, 1'b1, 3'd2, 1'b1, 1'b0));
    tick();
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL enemy_after_ally: got %b expected %b", o, e); else passed++;
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    apply_reset();
    ball(120, 405, 5);
    tick(); tick();
    ball_away();
    repeat (3) tick();
    sb.push_back(mk(1'b0, 1'b0, 3'd2, 1'b1, 1'b0));
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL pre_async_reset: got %b expected %b", o, e); else passed++;
    #3;
    reset = 1'b1;
    #1;
    sb.push_back(mk(1'b0, 1'b0, 3'd3, 1'b0, 1'b0));
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL async_reset: got %b expected %b", o, e); else passed++;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_restart_vs_hit();
    obs_t e, o;
    apply_reset();
    ball(120, 405, 5);
    tick();
    reiniciarJogo = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 3'd3, 1'b0, 1'b0));
    tick();
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL restart_priority: got %b expected %b", o, e); else passed++;
    reiniciarJogo = 1'b0;
    sb.push_back(mk(1'b1, 1'b1, 3'd2, 1'b1, 1'b0));
    tick();
    e = sb.pop_front(); o = dut_obs(); total++;
    if (o !== e) $display("FAIL hit_after_restart: got %b expected %b", o, e); else passed++;
  endtask

  initial begin
    test_reset();
    test_hit_latency();
    test_edges();
    test_persistent();
    test_game_over();
    test_pause();
    test_ally();
    test_async_reset();
    test_restart_vs_hit();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
